shift_unit_sched: RTL and testbench

//  Shares one iterative shift engine between two requesters (e.g. ALU issue and address-gen).

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_unit_sched_if.sv | 43 ++++
 rtl/shift_step.sv | 33 +++
 rtl/shift_unit_sched.sv | 114 +++++++++++
 tb/tb_shift_unit_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shared iterative shifter: op encodings, FSM states, default sizes.
// Nothing in here is clocked.
package shift_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int AW_DEF       = 5;
  localparam int MAX_STEP_DEF = 8;

  typedef enum logic [1:0] {
    OP_SRA = 2'b00,
    OP_SRL = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_sched_if.sv
// Two request ports plus one result port of the shared shifter, all valid/ready.
// master = requesters/consumer side, slave = the scheduler.
interface shift_unit_sched_if #(
  parameter int WIDTH = shift_pkg::WIDTH_DEF
);
  import shift_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  op_t              req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  op_t              req1_op;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_flag;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_flag, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_flag, res_id, busy
  );

endinterface

// File: rtl/shift_step.sv
// One EXEC step: shifts data by 0..MAX_STEP under op; combinational, no backpressure.
// Built as log2 stages of constant shifts so the mux cost tracks MAX_STEP, not WIDTH.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF,
  parameter int SW       = $clog2(MAX_STEP) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  op_t              op,
  input  logic [SW-1:0]    step,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] d;

  always_comb begin
    d = data;
    for (int k = 0; k < SW; k++) begin
      if (step[k]) begin
        case (op)
          OP_SRA:  d = $signed(d) >>> (1 << k);
          OP_SRL:  d = d >> (1 << k);
          OP_SLL:  d = d << (1 << k);
          default: d = (d >> (1 << k)) | (d << (WIDTH - (1 << k)));
        endcase
      end
    end
    res = d;
  end

endmodule

// File: rtl/shift_unit_sched.sv
// Round-robin shares one MAX_STEP-per-cycle shifter between two requesters; result after max(1,ceil(amt/MAX_STEP)) cycles.
// One op in flight: both request readies stay low until the result is taken with res_valid&res_ready.
module shift_unit_sched
  import shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AW       = AW_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF
) (
  input logic             clk,
  input logic             rst_n,
  shift_unit_sched_if.slave bus
);

  localparam int SW = $clog2(MAX_STEP) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_res;
  op_t              op_q;
  logic [AW-1:0]    rem_q;
  logic [AW-1:0]    rem_nxt;
  logic [SW-1:0]    step;
  logic             id_q;
  logic             last_grant;
  logic             grant0, grant1;
  logic             accept;
  logic             unused_b_hi;

  // Only the low AW bits of B carry the amount.
  assign unused_b_hi = ^{bus.req0_b[WIDTH-1:AW], bus.req1_b[WIDTH-1:AW]};

  // On a tie the requester not served last wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  assign accept = (state == ST_IDLE) & (grant0 | grant1);

  always_comb begin
    if (int'(rem_q) > MAX_STEP) begin
      step = SW'(MAX_STEP);
    end else begin
      step = SW'(rem_q);
    end
    rem_nxt = rem_q - AW'(step);
  end

  shift_step #(
    .WIDTH    (WIDTH),
    .MAX_STEP (MAX_STEP),
    .SW       (SW)
  ) u_step (
    .data (data_q),
    .op   (op_q),
    .step (step),
    .res  (step_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)         state_nxt = ST_EXEC;
      ST_EXEC: if (rem_nxt == '0)  state_nxt = ST_DONE;
      ST_DONE: if (bus.res_ready)  state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = (state == ST_IDLE) & grant0;
    bus.req1_ready = (state == ST_IDLE) & grant1;
    bus.res_valid  = (state == ST_DONE);
    bus.busy       = (state != ST_IDLE);
    bus.res_data   = data_q;
    bus.res_flag   = (state == ST_DONE) & ~(|data_q);
    bus.res_id     = id_q;
  end

  // Operand/result registers; data_q doubles as the result holding register in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      op_q       <= OP_SRA;
      rem_q      <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_q     <= grant1 ? bus.req1_a : bus.req0_a;
            rem_q      <= grant1 ? bus.req1_b[AW-1:0] : bus.req0_b[AW-1:0];
            op_q       <= grant1 ? bus.req1_op : bus.req0_op;
            id_q       <= grant1;
            last_grant <= grant1;
          end
        end
        ST_EXEC: begin
          data_q <= step_res;
          rem_q  <= rem_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_sched.sv
// Directed bench for shift_unit_sched: inputs driven 1 time unit after posedge,
// outputs sampled away from the edge, expected values hand-computed.
module tb_shift_unit_sched;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_unit_sched_if #(.WIDTH(32)) bus ();

  shift_unit_sched #(
    .WIDTH    (32),
    .AW       (5),
    .MAX_STEP (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_op    = OP_SRA;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_op    = OP_SRA;
    bus.res_ready  = 1'b1;
  endtask

  // Presents one request and returns just after the accepting edge (+1).
  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b, input op_t op);
    bit ok;
    ok = 1'b0;
    if (port) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      #1;
      if (port ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout port %0d got no ready want ready", port);
    end
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until res_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.res_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout got res_valid 0 want 1");
    end
  endtask

  task automatic handoff();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data got %h want 0", bus.res_data); end
    checks++; if (bus.res_flag !== 1'b0) begin errors++; $display("FAIL reset_res_flag got %b want 0", bus.res_flag); end
    checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got %b want 0", bus.res_id); end
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", bus.req0_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sra_basic();
    int lat;
    issue(1'b0, 32'h8000_0000, 32'd4, OP_SRA);
    wait_result(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sra_latency got %0d want 1", lat); end
    checks++; if (bus.res_data !== 32'hF800_0000) begin errors++; $display("FAIL sra_data got %h want f8000000", bus.res_data); end
    checks++; if (bus.res_flag !== 1'b0) begin errors++; $display("FAIL sra_flag got %b want 0", bus.res_flag); end
    checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL sra_id got %b want 0", bus.res_id); end
    handoff();
  endtask

  task automatic test_srl_long();
    int lat;
    issue(1'b1, 32'h0000_00F0, 32'd31, OP_SRL);
    wait_result(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL srl31_latency got %0d want 4", lat); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL srl31_data got %h want 0", bus.res_data); end
    checks++; if (bus.res_flag !== 1'b1) begin errors++; $display("FAIL srl31_flag got %b want 1", bus.res_flag); end
    checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL srl31_id got %b want 1", bus.res_id); end
    handoff();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL srl31_idle_after got %b want 0", bus.busy); end
  endtask

  task automatic test_ops();
    logic [31:0] va[6] = '{32'h1, 32'h1, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'hF0F0_F0F0};
    logic [31:0] vb[6] = '{32'h25, 32'h1, 32'h0, 32'd12, 32'd31, 32'd9};
    op_t         vo[6] = '{OP_SLL, OP_ROR, OP_SRL, OP_ROR, OP_SRA, OP_SLL};
    logic [31:0] ve[6] = '{32'h20, 32'h8000_0000, 32'h1234_5678, 32'h6781_2345, 32'hFFFF_FFFF, 32'hE1E1_E000};
    int          vl[6] = '{1, 1, 1, 2, 4, 2};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(i[0], va[i], vb[i], vo[i]);
      wait_result(lat);
      checks++; if (bus.res_data !== ve[i]) begin errors++; $display("FAIL ops_data[%0d] got %h want %h", i, bus.res_data, ve[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL ops_latency[%0d] got %0d want %0d", i, lat, vl[i]); end
      checks++; if (bus.res_id !== i[0]) begin errors++; $display("FAIL ops_id[%0d] got %b want %b", i, bus.res_id, i[0]); end
      handoff();
    end
  endtask

  task automatic test_alternate();
    int g[4] = '{-1, -1, -1, -1};
    int n;
    int bad;
    int lat;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req0_a = 32'h1; bus.req0_b = 32'h1; bus.req0_op = OP_SLL; bus.req0_valid = 1'b1;
    bus.req1_a = 32'h2; bus.req1_b = 32'h1; bus.req1_op = OP_SLL; bus.req1_valid = 1'b1;
    bus.res_ready = 1'b1;
    n = 0;
    bad = 0;
    for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
      #1;
      if (bus.busy && (bus.req0_ready || bus.req1_ready)) bad++;
      if (bus.req0_ready && bus.req1_ready) bad++;
      if (bus.req0_ready) begin
        g[n] = 0; n++;
      end else if (bus.req1_ready) begin
        g[n] = 1; n++;
      end
      @(posedge clk);
    end
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (g[i] !== (i % 2)) begin errors++; $display("FAIL alt_grant[%0d] got %0d want %0d", i, g[i], i % 2); end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL alt_ready_while_busy got %0d want 0", bad); end
    wait_result(lat);
    checks++; if (bus.res_data !== 32'h4) begin errors++; $display("FAIL alt_last_data got %h want 4", bus.res_data); end
    handoff();
  endtask

  task automatic test_stall();
    int lat;
    bus.res_ready = 1'b0;
    issue(1'b0, 32'h3, 32'd2, OP_SLL);
    wait_result(lat);
    bus.req1_a = 32'h5; bus.req1_b = 32'h0; bus.req1_op = OP_SRL; bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hC || bus.res_id !== 1'b0 ||
          bus.res_flag !== 1'b0 || bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h id=%b f=%b r0=%b r1=%b want v=1 d=0000000c id=0 f=0 r0=0 r1=0",
                 i, bus.res_valid, bus.res_data, bus.res_id, bus.res_flag, bus.req0_ready, bus.req1_ready);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_release_idle got %b want 0", bus.busy); end
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL stall_next_ready got %b want 1", bus.req1_ready); end
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_next_accept got %b want 1", bus.busy); end
    wait_result(lat);
    checks++; if (bus.res_data !== 32'h5) begin errors++; $display("FAIL stall_next_data got %h want 5", bus.res_data); end
    checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL stall_next_id got %b want 1", bus.res_id); end
    handoff();
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    // req0 served last, so without reset a tie would go to req1
    issue(1'b0, 32'hFFFF_FFFF, 32'd31, OP_SRL);
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_exec got busy %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid got %b want 0", bus.res_valid); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_result got %0d valid cycles want 0", seen); end
    bus.req0_a = 32'hA5; bus.req0_b = 32'h4; bus.req0_op = OP_SLL; bus.req0_valid = 1'b1;
    bus.req1_a = 32'h1;  bus.req1_b = 32'h0; bus.req1_op = OP_SRL; bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tie_req0 got %b want 1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tie_req1 got %b want 0", bus.req1_ready); end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_result(lat);
    checks++; if (bus.res_data !== 32'hA50) begin errors++; $display("FAIL rstmid_after_data got %h want a50", bus.res_data); end
    handoff();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_sra_basic();
    test_srl_long();
    test_ops();
    test_alternate();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
